instr_register_exec: RTL and testbench
======================================

Name: instr_register_exec

Overview:
- Parametrised successor to the lab instruction register: DEPTH-entry register file of instructions {opc, op_a, op_b, rez}, plus per-entry done/err status.
- Instructions are accepted through a ready/enable load handshake. An internal execute FSM computes rez and writes it back: one cycle for most opcodes, iterative for POW.
- A registered read port returns any stored entry.
- Sits between the testbench/stimulus driver and the checker.

Parameters:
- OP_WIDTH, 32, signed operand width.
- RES_WIDTH, 2*OP_WIDTH, signed result width. Must be >= 2*OP_WIDTH.
- DEPTH, 32, number of entries. Power of two.
- MAX_POW, 63, largest accepted POW exponent.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- load_en  in  1  load request.
- load_ready  out  1  block can accept a load this cycle.
- write_pointer  in  $clog2(DEPTH)  target entry of the load.
- opcode  in  opcode_t(4)  instruction opcode.
- operand_a  in  OP_WIDTH  signed operand A.
- operand_b  in  OP_WIDTH  signed operand B.
- read_en  in  1  read request.
- read_pointer  in  $clog2(DEPTH)  entry to read.
- read_valid  out  1  one-cycle pulse; read outputs are valid.
- rd_opc / rd_op_a / rd_op_b / rd_rez / rd_done / rd_err  out  4/OP_WIDTH/OP_WIDTH/RES_WIDTH/1/1  contents of the read entry.
- exec_done  out  1  one-cycle pulse when a result is written.
- exec_addr  out  $clog2(DEPTH)  entry written; valid while exec_done is high.

Behaviour:
- Reset (sampled at a clk edge):
  - All entries cleared: opc=ZERO, operands 0, rez 0, done 0, err 0.
  - FSM goes to IDLE; load_ready=1, read_valid=0, exec_done=0, exec_addr=0, all rd_* = 0.
  - Reset mid-EXEC or mid-POW aborts the operation; no writeback occurs.
- Load handshake:
  - A load is accepted on the edge where load_en && load_ready.
  - On accept, the entry gets opc/op_a/op_b, rez=0, done=0, err=0. The operands are latched into the execute unit.
  - load_ready=1 only in IDLE. load_en while load_ready=0 is ignored with no side effects.
- FSM states: IDLE -> EXEC (always, the edge after accept).
  - EXEC, non-POW opcode: write rez/err, done=1, exec_done pulse, return to IDLE.
  - Latency from accept edge E0 to result: rez visible after edge E1; load_ready low for exactly one cycle.
  - EXEC, POW, special cases (all written at E1):
    - op_b==0: rez=1.
    - op_b<0: rez=0, err=0.
    - op_b>MAX_POW: rez=0, err=1.
  - EXEC, POW, 0<op_b<=MAX_POW: go to POW with acc=1 and cnt=op_b.
  - POW state: each cycle acc = acc*op_a truncated to RES_WIDTH, cnt--. When cnt reaches 0, write rez=acc at that edge and return to IDLE.
  - POW writeback occurs after edge E(1+op_b).
- Arithmetic: signed; operands sign-extended to RES_WIDTH.
  - ZERO=0; PASSA=a; PASSB=b; ADD=a+b; SUB=a-b; MULT=full a*b.
  - DIV truncates toward zero; MOD takes the sign of the dividend.
  - DIV or MOD with b==0: rez=0, err=1.
  - Opcodes 9..15: rez=0, err=1.
  - MIN/-1 gives +2^(OP_WIDTH-1) exactly, with no error.
- Read port:
  - read_en sampled at edge; rd_* hold the entry contents as they were before that edge; read_valid=1 for one cycle.
  - Same-cycle read and writeback to the same entry returns the old contents.
  - rd_* hold their value when read_valid=0.
  - Reads are allowed in every state.
- exec_done / exec_addr: registered, asserted in the cycle after the writeback edge.

Decomposition:
- instr_register_pkg holds:
  - opcode_t (4-bit, ZERO..POW = 0..8, unchanged encoding).
  - exec_state_t enum {IDLE, EXEC, POW}.
  - Default width constants.
- Width-dependent operand/result/struct types are declared inside the module from its parameters.
- Sub-module instr_exec_unit holds the FSM, the arithmetic and the POW iterator. The top level holds storage, the handshake and the read port.

Test Plan:
- Reset, then read entries 0 and 31 -> read_valid=1, all fields 0, done=0; load_ready=1.
- Load ADD a=7 b=-10 at ptr 3 -> load_ready low one cycle; exec_done with exec_addr=3 the cycle after E1; read ptr 3 -> rez=-3, done=1, err=0.
- Load MULT a=-2147483648 b=-2147483648 -> rez=64'h4000_0000_0000_0000. Load DIV a=-7 b=2 -> rez=-3. Load MOD a=-7 b=2 -> rez=-1. Load DIV b=0 -> rez=0, err=1.
- Load POW a=3 b=4 -> load_ready low 5 cycles, rez=81. POW b=0 -> rez=1 at E1. POW b=64 -> rez=0, err=1. Hold load_en high while busy -> no extra entry is written.
- Assert reset during POW a=2 b=40 iteration 10 -> no exec_done; entry cleared; load_ready=1 after the reset edge.
- Read ptr 5 on the same edge as ptr 5 POW writeback -> rd_done=0, rd_rez=0; a second read -> done=1 with the result.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared opcode encoding, execute FSM state type and default widths for the instruction register.
// Latency: none, types and constants only.
// Backpressure: none.
package instr_register_pkg;

    localparam int DEF_OP_WIDTH = 32;
    localparam int DEF_DEPTH    = 32;
    localparam int DEF_MAX_POW  = 63;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7,
        POW   = 4'd8
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_POW  = 2'd2
    } exec_state_t;

endpackage

// File: rtl/instr_exec_unit.sv
// Execute FSM: computes rez for the latched instruction and issues exactly one writeback.
// Latency: writeback 1 edge after accept, or 1+op_b edges for an in-range POW.
// Backpressure: idle is low from accept until the writeback edge; start is only honoured while idle.
module instr_exec_unit
    import instr_register_pkg::*;
#(
    parameter int OP_WIDTH  = DEF_OP_WIDTH,
    parameter int RES_WIDTH = 2 * OP_WIDTH,
    parameter int AW        = 5,
    parameter int MAX_POW   = DEF_MAX_POW
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [AW-1:0]               start_addr,
    input  logic [3:0]                  start_opc,
    input  logic signed [OP_WIDTH-1:0]  start_a,
    input  logic signed [OP_WIDTH-1:0]  start_b,
    output logic                        idle,
    output logic                        wb_vld,
    output logic [AW-1:0]               wb_addr,
    output logic signed [RES_WIDTH-1:0] wb_rez,
    output logic                        wb_err
);

    localparam int CW = $clog2(MAX_POW + 1);
    localparam logic signed [OP_WIDTH-1:0] MAX_POW_V = OP_WIDTH'(MAX_POW);

    exec_state_t                 state;
    logic [3:0]                  opc_q;
    logic [AW-1:0]               addr_q;
    logic signed [OP_WIDTH-1:0]  a_q;
    logic signed [OP_WIDTH-1:0]  b_q;
    logic signed [RES_WIDTH-1:0] acc;
    logic [CW-1:0]               cnt;

    logic signed [RES_WIDTH-1:0] a_ext;
    logic signed [RES_WIDTH-1:0] b_ext;
    logic signed [RES_WIDTH-1:0] acc_nxt;
    logic signed [RES_WIDTH-1:0] alu_rez;
    logic                        alu_err;
    logic                        b_zero;
    logic                        b_neg;
    logic                        b_over;
    logic                        go_pow;

    // Widening before the divide makes MIN/-1 representable without a special case.
    assign a_ext = {{(RES_WIDTH-OP_WIDTH){a_q[OP_WIDTH-1]}}, a_q};
    assign b_ext = {{(RES_WIDTH-OP_WIDTH){b_q[OP_WIDTH-1]}}, b_q};

    assign b_zero  = (b_q == '0);
    assign b_neg   = b_q[OP_WIDTH-1];
    assign b_over  = (b_q > MAX_POW_V);
    assign go_pow  = (opc_q == POW) && !b_zero && !b_neg && !b_over;
    assign acc_nxt = acc * a_ext;

    always_comb begin
        alu_rez = '0;
        alu_err = 1'b0;
        case (opc_q)
            ZERO:  alu_rez = '0;
            PASSA: alu_rez = a_ext;
            PASSB: alu_rez = b_ext;
            ADD:   alu_rez = a_ext + b_ext;
            SUB:   alu_rez = a_ext - b_ext;
            MULT:  alu_rez = a_ext * b_ext;
            DIV: begin
                if (b_zero) alu_err = 1'b1;
                else        alu_rez = a_ext / b_ext;
            end
            MOD: begin
                if (b_zero) alu_err = 1'b1;
                else        alu_rez = a_ext % b_ext;
            end
            POW: begin
                // Negative exponent yields 0 without error; in-range exponents iterate.
                if (b_zero)      alu_rez = RES_WIDTH'(1);
                else if (b_over) alu_err = 1'b1;
            end
            default: alu_err = 1'b1;
        endcase
    end

    assign idle    = (state == ST_IDLE);
    assign wb_addr = addr_q;

    always_comb begin
        wb_vld = 1'b0;
        wb_rez = alu_rez;
        wb_err = alu_err;
        if (state == ST_EXEC) begin
            wb_vld = !go_pow;
        end else if (state == ST_POW) begin
            wb_vld = (cnt == CW'(1));
            wb_rez = acc_nxt;
            wb_err = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            opc_q  <= '0;
            addr_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_EXEC;
                        opc_q  <= start_opc;
                        addr_q <= start_addr;
                        a_q    <= start_a;
                        b_q    <= start_b;
                    end
                end
                ST_EXEC: begin
                    if (go_pow) begin
                        state <= ST_POW;
                        acc   <= RES_WIDTH'(1);
                        cnt   <= b_q[CW-1:0];
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_POW: begin
                    acc <= acc_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/instr_register_exec.sv
// Instruction register file with load handshake, execute writeback and registered read port.
// Latency: result stored 1 edge after load (1+op_b for POW); reads return data 1 edge after read_en.
// Backpressure: load_ready low while an instruction executes; reads are never stalled.
module instr_register_exec
    import instr_register_pkg::*;
#(
    parameter int OP_WIDTH  = DEF_OP_WIDTH,
    parameter int RES_WIDTH = 2 * OP_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int MAX_POW   = DEF_MAX_POW
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_en,
    output logic                       load_ready,
    input  logic [$clog2(DEPTH)-1:0]   write_pointer,
    input  logic [3:0]                 opcode,
    input  logic signed [OP_WIDTH-1:0] operand_a,
    input  logic signed [OP_WIDTH-1:0] operand_b,
    input  logic                       read_en,
    input  logic [$clog2(DEPTH)-1:0]   read_pointer,
    output logic                       read_valid,
    output logic [3:0]                 rd_opc,
    output logic [OP_WIDTH-1:0]        rd_op_a,
    output logic [OP_WIDTH-1:0]        rd_op_b,
    output logic [RES_WIDTH-1:0]       rd_rez,
    output logic                       rd_done,
    output logic                       rd_err,
    output logic                       exec_done,
    output logic [$clog2(DEPTH)-1:0]   exec_addr
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0]                  opc;
        logic signed [OP_WIDTH-1:0]  op_a;
        logic signed [OP_WIDTH-1:0]  op_b;
        logic signed [RES_WIDTH-1:0] rez;
        logic                        done;
        logic                        err;
    } entry_t;

    entry_t                      regs [DEPTH];
    entry_t                      rd_q;
    logic                        load_acc;
    logic                        unit_idle;
    logic                        wb_vld;
    logic [AW-1:0]               wb_addr;
    logic signed [RES_WIDTH-1:0] wb_rez;
    logic                        wb_err;

    assign load_ready = unit_idle;
    assign load_acc   = load_en && load_ready;

    instr_exec_unit #(
        .OP_WIDTH  (OP_WIDTH),
        .RES_WIDTH (RES_WIDTH),
        .AW        (AW),
        .MAX_POW   (MAX_POW)
    ) u_exec (
        .clk        (clk),
        .reset      (reset),
        .start      (load_acc),
        .start_addr (write_pointer),
        .start_opc  (opcode),
        .start_a    (operand_a),
        .start_b    (operand_b),
        .idle       (unit_idle),
        .wb_vld     (wb_vld),
        .wb_addr    (wb_addr),
        .wb_rez     (wb_rez),
        .wb_err     (wb_err)
    );

    // Loads and writebacks never coincide: loads need an idle unit, writebacks need a busy one.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (load_acc) begin
                regs[write_pointer] <= '{opc:  opcode,
                                         op_a: operand_a,
                                         op_b: operand_b,
                                         rez:  '0,
                                         done: 1'b0,
                                         err:  1'b0};
            end
            if (wb_vld) begin
                regs[wb_addr].rez  <= wb_rez;
                regs[wb_addr].done <= 1'b1;
                regs[wb_addr].err  <= wb_err;
            end
        end
    end

    // Nonblocking update gives read-before-write on a same-edge writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q       <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= read_en;
            if (read_en) rd_q <= regs[read_pointer];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exec_done <= 1'b0;
            exec_addr <= '0;
        end else begin
            exec_done <= wb_vld;
            if (wb_vld) exec_addr <= wb_addr;
        end
    end

    assign rd_opc  = rd_q.opc;
    assign rd_op_a = rd_q.op_a;
    assign rd_op_b = rd_q.op_b;
    assign rd_rez  = rd_q.rez;
    assign rd_done = rd_q.done;
    assign rd_err  = rd_q.err;

endmodule

// File: tb/tb_instr_register_exec.sv
// Self-checking bench for instr_register_exec: scoreboard of expected writebacks popped on exec_done.
module tb_instr_register_exec;
    import instr_register_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               load_en;
    logic               load_ready;
    logic [4:0]         write_pointer;
    logic [3:0]         opcode;
    logic signed [31:0] operand_a;
    logic signed [31:0] operand_b;
    logic               read_en;
    logic [4:0]         read_pointer;
    logic               read_valid;
    logic [3:0]         rd_opc;
    logic [31:0]        rd_op_a;
    logic [31:0]        rd_op_b;
    logic [63:0]        rd_rez;
    logic               rd_done;
    logic               rd_err;
    logic               exec_done;
    logic [4:0]         exec_addr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]         addr;
        logic [3:0]         opc;
        logic signed [31:0] a;
        logic signed [31:0] b;
        logic signed [63:0] rez;
        logic               err;
        int                 lat;
    } exp_t;

    exp_t exp_q[$];

    instr_register_exec #(
        .OP_WIDTH  (32),
        .RES_WIDTH (64),
        .DEPTH     (32),
        .MAX_POW   (63)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .load_en       (load_en),
        .load_ready    (load_ready),
        .write_pointer (write_pointer),
        .opcode        (opcode),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .read_en       (read_en),
        .read_pointer  (read_pointer),
        .read_valid    (read_valid),
        .rd_opc        (rd_opc),
        .rd_op_a       (rd_op_a),
        .rd_op_b       (rd_op_b),
        .rd_rez        (rd_rez),
        .rd_done       (rd_done),
        .rd_err        (rd_err),
        .exec_done     (exec_done),
        .exec_addr     (exec_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // All tasks start and end at a falling edge.
    task automatic do_load(input logic [4:0] ptr, input logic [3:0] op,
                           input logic signed [31:0] a, input logic signed [31:0] b);
        load_en       = 1'b1;
        write_pointer = ptr;
        opcode        = op;
        operand_a     = a;
        operand_b     = b;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] ptr);
        read_en      = 1'b1;
        read_pointer = ptr;
        @(negedge clk);
        read_en = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [4:0] ptr, input logic [3:0] op,
                          input logic signed [31:0] a, input logic signed [31:0] b,
                          input logic signed [63:0] er, input logic ee, input int lat);
        exp_t e;
        int   cyc;
        int   low;
        bit   seen;
        exp_q.push_back('{addr: ptr, opc: op, a: a, b: b, rez: er, err: ee, lat: lat});
        do_load(ptr, op, a, b);
        cyc  = 0;
        low  = (load_ready === 1'b0) ? 1 : 0;
        seen = 0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (exec_done === 1'b1) seen = 1;
            else if (load_ready === 1'b0) low++;
        end
        e = exp_q.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: exec_done not seen within 200 cycles, required after %0d", name, e.lat);
            return;
        end
        checks++;
        if (cyc !== e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc, e.lat);
        end
        checks++;
        if (low !== e.lat) begin
            errors++;
            $display("FAIL %s load_ready low: got %0d cycles, expected %0d", name, low, e.lat);
        end
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s load_ready after writeback: got %b expected 1", name, load_ready);
        end
        checks++;
        if (exec_addr !== e.addr) begin
            errors++;
            $display("FAIL %s exec_addr: got %0d expected %0d", name, exec_addr, e.addr);
        end
        do_read(e.addr);
        checks++;
        if (exec_done !== 1'b0) begin
            errors++;
            $display("FAIL %s exec_done pulse width: got %b expected 0", name, exec_done);
        end
        checks++;
        if (read_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s read_valid: got %b expected 1", name, read_valid);
        end
        checks++;
        if (rd_rez !== e.rez || rd_err !== e.err || rd_done !== 1'b1) begin
            errors++;
            $display("FAIL %s result: got rez=%h err=%b done=%b expected rez=%h err=%b done=1",
                     name, rd_rez, rd_err, rd_done, e.rez, e.err);
        end
        checks++;
        if (rd_opc !== e.opc || rd_op_a !== e.a || rd_op_b !== e.b) begin
            errors++;
            $display("FAIL %s stored fields: got opc=%0d a=%h b=%h expected opc=%0d a=%h b=%h",
                     name, rd_opc, rd_op_a, rd_op_b, e.opc, e.a, e.b);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load_en = 1'b0; read_en = 1'b0;
        write_pointer = '0; read_pointer = '0; opcode = '0; operand_a = '0; operand_b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (load_ready !== 1'b1 || read_valid !== 1'b0 || exec_done !== 1'b0 || exec_addr !== 5'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got ready=%b rvalid=%b done=%b addr=%0d expected 1 0 0 0",
                     load_ready, read_valid, exec_done, exec_addr);
        end
        checks++;
        if (rd_rez !== 64'd0 || rd_opc !== 4'd0 || rd_op_a !== 32'd0 || rd_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd: got rez=%h opc=%0d a=%h done=%b expected all 0",
                     rd_rez, rd_opc, rd_op_a, rd_done);
        end
        for (int p = 0; p < 32; p += 31) begin
            do_read(5'(p));
            checks++;
            if (read_valid !== 1'b1 || rd_opc !== 4'd0 || rd_op_a !== 32'd0 || rd_op_b !== 32'd0 ||
                rd_rez !== 64'd0 || rd_done !== 1'b0 || rd_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_entry%0d: got v=%b opc=%0d a=%h b=%h rez=%h done=%b err=%b expected v=1 rest 0",
                         p, read_valid, rd_opc, rd_op_a, rd_op_b, rd_rez, rd_done, rd_err);
            end
        end
    endtask

    task automatic test_alu();
        run_op("add",      5'd3,  ADD,   32'sd7,    -32'sd10,   -64'sd3,       1'b0, 1);
        run_op("sub",      5'd4,  SUB,   32'sd5,    32'sd12,    -64'sd7,       1'b0, 1);
        run_op("passa",    5'd6,  PASSA, -32'sd9,   32'sd4,     -64'sd9,       1'b0, 1);
        run_op("passb",    5'd7,  PASSB, 32'sd0,    32'sd123,   64'sd123,      1'b0, 1);
        run_op("zero",     5'd8,  ZERO,  32'sd5,    32'sd6,     64'sd0,        1'b0, 1);
        run_op("mult_min", 5'd9,  MULT,  32'sh8000_0000, 32'sh8000_0000, 64'sh4000_0000_0000_0000, 1'b0, 1);
        run_op("mult_neg", 5'd10, MULT,  -32'sd3,   32'sd100000, -64'sd300000, 1'b0, 1);
        run_op("div_neg",  5'd11, DIV,   -32'sd7,   32'sd2,     -64'sd3,       1'b0, 1);
        run_op("mod_neg",  5'd12, MOD,   -32'sd7,   32'sd2,     -64'sd1,       1'b0, 1);
        run_op("mod_negb", 5'd15, MOD,   32'sd7,    -32'sd2,    64'sd1,        1'b0, 1);
        run_op("div_zero", 5'd16, DIV,   32'sd5,    32'sd0,     64'sd0,        1'b1, 1);
        run_op("mod_zero", 5'd17, MOD,   32'sd5,    32'sd0,     64'sd0,        1'b1, 1);
        run_op("div_minm1", 5'd18, DIV,  32'sh8000_0000, -32'sd1, 64'sd2147483648, 1'b0, 1);
        run_op("opc9",     5'd19, 4'd9,  32'sd1,    32'sd2,     64'sd0,        1'b1, 1);
        run_op("opc15",    5'd0,  4'd15, 32'sd1,    32'sd2,     64'sd0,        1'b1, 1);
    endtask

    task automatic test_pow();
        run_op("pow_3_4",  5'd21, POW, 32'sd3,  32'sd4,  64'sd81, 1'b0, 5);
        run_op("pow_b0",   5'd22, POW, 32'sd7,  32'sd0,  64'sd1,  1'b0, 1);
        run_op("pow_b64",  5'd23, POW, 32'sd2,  32'sd64, 64'sd0,  1'b1, 1);
        run_op("pow_bneg", 5'd24, POW, 32'sd2,  -32'sd1, 64'sd0,  1'b0, 1);
        run_op("pow_neg",  5'd25, POW, -32'sd2, 32'sd3,  -64'sd8, 1'b0, 4);
        run_op("pow_max",  5'd26, POW, 32'sd2,  32'sd63, 64'sh8000_0000_0000_0000, 1'b0, 64);
    endtask

    task automatic test_busy_load();
        exp_t e;
        int   cyc;
        int   extra;
        bit   seen;
        exp_q.push_back('{addr: 5'd13, opc: POW, a: 32'sd3, b: 32'sd4, rez: 64'sd81, err: 1'b0, lat: 5});
        load_en = 1'b1; write_pointer = 5'd13; opcode = POW; operand_a = 32'sd3; operand_b = 32'sd4;
        @(negedge clk);
        write_pointer = 5'd14; opcode = ADD; operand_a = 32'sd1; operand_b = 32'sd1;
        repeat (4) @(negedge clk);
        load_en = 1'b0;
        cyc = 0; seen = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (exec_done === 1'b1) seen = 1;
        end
        e = exp_q.pop_front();
        checks++;
        if (!seen || exec_addr !== e.addr) begin
            errors++;
            $display("FAIL busy_wb: got seen=%b addr=%0d expected seen=1 addr=%0d", seen, exec_addr, e.addr);
        end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (exec_done === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL busy_extra_exec: got %0d extra exec_done pulses expected 0", extra);
        end
        do_read(5'd13);
        checks++;
        if (rd_rez !== e.rez || rd_done !== 1'b1) begin
            errors++;
            $display("FAIL busy_entry13: got rez=%h done=%b expected rez=%h done=1", rd_rez, rd_done, e.rez);
        end
        do_read(5'd14);
        checks++;
        if (rd_opc !== 4'd0 || rd_op_a !== 32'd0 || rd_done !== 1'b0) begin
            errors++;
            $display("FAIL busy_entry14: got opc=%0d a=%h done=%b expected 0 0 0", rd_opc, rd_op_a, rd_done);
        end
    endtask

    task automatic test_reset_mid_pow();
        int pulses;
        do_load(5'd20, POW, 32'sd2, 32'sd40);
        repeat (10) @(negedge clk);
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstpow_busy: got load_ready=%b expected 0", load_ready);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (load_ready !== 1'b1 || exec_done !== 1'b0 || read_valid !== 1'b0 || rd_rez !== 64'd0) begin
            errors++;
            $display("FAIL rstpow_ctrl: got ready=%b done=%b rvalid=%b rez=%h expected 1 0 0 0",
                     load_ready, exec_done, read_valid, rd_rez);
        end
        pulses = 0;
        repeat (50) begin
            @(negedge clk);
            if (exec_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL rstpow_nowb: got %0d exec_done pulses expected 0", pulses);
        end
        do_read(5'd20);
        checks++;
        if (rd_opc !== 4'd0 || rd_op_b !== 32'd0 || rd_rez !== 64'd0 || rd_done !== 1'b0) begin
            errors++;
            $display("FAIL rstpow_entry20: got opc=%0d b=%h rez=%h done=%b expected all 0",
                     rd_opc, rd_op_b, rd_rez, rd_done);
        end
        do_read(5'd3);
        checks++;
        if (rd_rez !== 64'd0 || rd_done !== 1'b0) begin
            errors++;
            $display("FAIL rstpow_entry3: got rez=%h done=%b expected 0 0", rd_rez, rd_done);
        end
    endtask

    task automatic test_read_collision();
        exp_t e;
        exp_q.push_back('{addr: 5'd5, opc: POW, a: 32'sd3, b: 32'sd2, rez: 64'sd9, err: 1'b0, lat: 3});
        do_load(5'd5, POW, 32'sd3, 32'sd2);
        repeat (2) @(negedge clk);
        do_read(5'd5);
        checks++;
        if (exec_done !== 1'b1) begin
            errors++;
            $display("FAIL coll_exec_done: got %b expected 1", exec_done);
        end
        e = exp_q.pop_front();
        checks++;
        if (read_valid !== 1'b1 || rd_done !== 1'b0 || rd_rez !== 64'd0 || rd_opc !== e.opc) begin
            errors++;
            $display("FAIL coll_old: got v=%b done=%b rez=%h opc=%0d expected v=1 done=0 rez=0 opc=%0d",
                     read_valid, rd_done, rd_rez, rd_opc, e.opc);
        end
        do_read(5'd5);
        checks++;
        if (rd_done !== 1'b1 || rd_rez !== e.rez || rd_err !== e.err) begin
            errors++;
            $display("FAIL coll_new: got done=%b rez=%h err=%b expected done=1 rez=%h err=%b",
                     rd_done, rd_rez, rd_err, e.rez, e.err);
        end
        @(negedge clk);
        checks++;
        if (read_valid !== 1'b0 || rd_rez !== e.rez) begin
            errors++;
            $display("FAIL rd_hold: got v=%b rez=%h expected v=0 rez=%h", read_valid, rd_rez, e.rez);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_pow();
        test_busy_load();
        test_reset_mid_pow();
        test_read_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
